// File: rtl/lv_pkg.sv
// Shared types for the low-voltage die mode controller: state encoding, SPI
// mode request codes and the reg_mode_str bus seen by every mode consumer.
package lv_pkg;

    typedef enum logic [2:0] {
        RST_ST   = 3'd0,
        NML_ST   = 3'd1,
        CFG_ST   = 3'd2,
        BIST_ST  = 3'd3,
        FSISO_ST = 3'd4
    } lv_mode_st_e;

    localparam logic [2:0] MODE_NML    = 3'd0;
    localparam logic [2:0] MODE_CFG    = 3'd1;
    localparam logic [2:0] MODE_CFG_WR = 3'd2;
    localparam logic [2:0] MODE_BIST   = 3'd3;

    localparam int CFG_TMO  = 1024;
    localparam int BIST_TMO = 4096;
    localparam int TMO_W    = 13;

    typedef struct packed {
        logic efuse_done;
        logic adc2_en;
        logic adc1_en;
        logic fsiso_en;
        logic bist_en;
        logic cfg_en;
        logic normal_en;
        logic reset_en;
    } reg_mode_str;

    // Builds the one-hot mode group plus the sticky/independent bits.
    function automatic reg_mode_str mode_bits(lv_mode_st_e st, logic efuse, logic [1:0] adc);
        reg_mode_str r;
        r            = '0;
        r.efuse_done = efuse;
        r.adc2_en    = adc[1];
        r.adc1_en    = adc[0];
        r.reset_en   = (st == RST_ST);
        r.normal_en  = (st == NML_ST);
        r.cfg_en     = (st == CFG_ST);
        r.bist_en    = (st == BIST_ST);
        r.fsiso_en   = (st == FSISO_ST);
        return r;
    endfunction

endpackage

// File: rtl/lv_tmo_cnt.sv
// Saturating up-counter with synchronous clear; hit flags count >= limit
// while counting is enabled.
module lv_tmo_cnt #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // >= rather than == so a saturated count can never strand the FSM.
    assign hit = en && (cnt_q >= limit);

endmodule

// File: rtl/lv_mode_fsm.sv
// Operating-mode controller: reset -> efuse load -> normal, SPI cfg/bist
// arbitration, fault/BIST-timeout isolation. Sole producer of reg_mode.
module lv_mode_fsm
    import lv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       efuse_ld_done,
    input  logic       mode_req_vld,
    input  logic [2:0] mode_req_code,
    input  logic [1:0] adc_en_wr,
    input  logic       bist_done,
    input  logic       fault,
    input  logic       fsiso_clr,
    output logic [7:0] reg_mode,
    output logic       mode_ack,
    output logic       mode_err,
    output logic       bist_tmo
);

    lv_mode_st_e state_q, state_d;
    reg_mode_str reg_mode_q, reg_mode_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        bist_tmo_q, bist_tmo_d;
    logic        efuse_q, efuse_d;
    logic [1:0]  adc_q, adc_d;
    logic        restart;
    logic        tmo_hit;
    logic [TMO_W-1:0] tmo_limit;

    assign tmo_limit = (state_q == BIST_ST) ? TMO_W'(BIST_TMO - 1) : TMO_W'(CFG_TMO - 1);

    lv_tmo_cnt #(.W(TMO_W)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_d != state_q) || restart),
        .en    ((state_q == CFG_ST) || (state_q == BIST_ST)),
        .limit (tmo_limit),
        .hit   (tmo_hit)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        bist_tmo_d = bist_tmo_q;
        efuse_d    = efuse_q;
        adc_d      = adc_q;
        restart    = 1'b0;

        if (fault && (state_q != RST_ST)) begin
            state_d = FSISO_ST;
            err_d   = mode_req_vld || (fsiso_clr && (state_q == FSISO_ST));
        end else begin
            case (state_q)
                RST_ST: begin
                    err_d = mode_req_vld;
                    if (efuse_ld_done) begin
                        state_d = NML_ST;
                        efuse_d = 1'b1;
                    end
                end
                NML_ST: begin
                    if (mode_req_vld) begin
                        if (mode_req_code == MODE_CFG) begin
                            state_d = CFG_ST;
                            ack_d   = 1'b1;
                        end else if (mode_req_code == MODE_BIST) begin
                            state_d = BIST_ST;
                            ack_d   = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                end
                CFG_ST: begin
                    if (mode_req_vld && (mode_req_code == MODE_CFG_WR)) begin
                        adc_d   = adc_en_wr;
                        ack_d   = 1'b1;
                        restart = 1'b1;
                    end else if (mode_req_vld && (mode_req_code == MODE_NML)) begin
                        state_d = NML_ST;
                        ack_d   = 1'b1;
                    end else begin
                        err_d = mode_req_vld;
                        if (tmo_hit)
                            state_d = NML_ST;
                    end
                end
                BIST_ST: begin
                    err_d = mode_req_vld;
                    if (bist_done) begin
                        state_d = NML_ST;
                    end else if (tmo_hit) begin
                        state_d    = FSISO_ST;
                        bist_tmo_d = 1'b1;
                    end
                end
                FSISO_ST: begin
                    err_d = mode_req_vld;
                    if (fsiso_clr) begin
                        state_d = NML_ST;
                        ack_d   = 1'b1;
                    end
                end
                default: state_d = RST_ST;
            endcase
        end

        // ADC enables are only meaningful outside BIST and isolation.
        if ((state_d == BIST_ST) || (state_d == FSISO_ST))
            adc_d = 2'b00;

        reg_mode_d = mode_bits(state_d, efuse_d, adc_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_ST;
            reg_mode_q <= 8'h01;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            bist_tmo_q <= 1'b0;
            efuse_q    <= 1'b0;
            adc_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            reg_mode_q <= reg_mode_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            bist_tmo_q <= bist_tmo_d;
            efuse_q    <= efuse_d;
            adc_q      <= adc_d;
        end
    end

    assign reg_mode = reg_mode_q;
    assign mode_ack = ack_q;
    assign mode_err = err_q;
    assign bist_tmo = bist_tmo_q;

endmodule

// File: tb/tb_lv_mode_fsm.sv
// Scoreboard bench for lv_mode_fsm: expected pulses/reg_mode queued with each
// stimulus cycle and compared one cycle later.
module tb_lv_mode_fsm;
    import lv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       efuse_ld_done = 1'b0;
    logic       mode_req_vld = 1'b0;
    logic [2:0] mode_req_code = 3'd0;
    logic [1:0] adc_en_wr = 2'b00;
    logic       bist_done = 1'b0;
    logic       fault = 1'b0;
    logic       fsiso_clr = 1'b0;
    logic [7:0] reg_mode;
    logic       mode_ack;
    logic       mode_err;
    logic       bist_tmo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       ack;
        logic       err;
        logic [7:0] rm;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    lv_mode_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .efuse_ld_done (efuse_ld_done),
        .mode_req_vld  (mode_req_vld),
        .mode_req_code (mode_req_code),
        .adc_en_wr     (adc_en_wr),
        .bist_done     (bist_done),
        .fault         (fault),
        .fsiso_clr     (fsiso_clr),
        .reg_mode      (reg_mode),
        .mode_ack      (mode_ack),
        .mode_err      (mode_err),
        .bist_tmo      (bist_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: push expectation, advance past the edge, compare, drop strobes.
    task automatic step(input string tag, input logic ack, input logic err, input logic [7:0] rm);
        exp_t e;
        exp_t o;
        e.tag = tag; e.ack = ack; e.err = err; e.rm = rm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk({o.tag, ".ack"}, {31'd0, mode_ack}, {31'd0, o.ack});
        chk({o.tag, ".err"}, {31'd0, mode_err}, {31'd0, o.err});
        chk({o.tag, ".rm"},  {24'd0, reg_mode}, {24'd0, o.rm});
        mode_req_vld = 1'b0;
        bist_done    = 1'b0;
        fsiso_clr    = 1'b0;
    endtask

    task automatic req(input string tag, input logic [2:0] code, input logic [1:0] wr,
                       input logic ack, input logic err, input logic [7:0] rm);
        mode_req_vld  = 1'b1;
        mode_req_code = code;
        adc_en_wr     = wr;
        step(tag, ack, err, rm);
    endtask

    // Idle for n cycles; report any stray pulse or reg_mode change once.
    task automatic idle(input string tag, input int n, input logic [7:0] rm);
        int pulses = 0;
        int wrong  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (mode_ack || mode_err) pulses++;
            if (reg_mode !== rm) wrong++;
        end
        chk({tag, ".pulses"}, pulses, 0);
        chk({tag, ".rm_held"}, wrong, 0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst.rm", {24'd0, reg_mode}, 32'h01);
        chk("rst.ack", {31'd0, mode_ack}, 0);
        chk("rst.err", {31'd0, mode_err}, 0);
        chk("rst.tmo", {31'd0, bist_tmo}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: request in RST rejected, then efuse load
        req("t1_rst_req", MODE_CFG, 2'b00, 1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 3; i++) step("t1_wait", 1'b0, 1'b0, 8'h01);
        efuse_ld_done = 1'b1;
        step("t1_efuse", 1'b0, 1'b0, 8'h82);
        step("t1_nml", 1'b0, 1'b0, 8'h82);

        // T2: cfg, write adc, illegal in cfg, back to normal, illegal in normal
        req("t2_cfg", MODE_CFG, 2'b00, 1'b1, 1'b0, 8'h84);
        req("t2_wr", MODE_CFG_WR, 2'b11, 1'b1, 1'b0, 8'hE4);
        req("t2_cfg_bad", MODE_BIST, 2'b00, 1'b0, 1'b1, 8'hE4);
        req("t2_nml", MODE_NML, 2'b00, 1'b1, 1'b0, 8'hE2);
        req("t2_nml_bad", MODE_CFG_WR, 2'b01, 1'b0, 1'b1, 8'hE2);
        req("t2_nml_bad7", 3'd7, 2'b00, 1'b0, 1'b1, 8'hE2);

        // T3: cfg inactivity timeout after exactly CFG_TMO cycles
        req("t3_cfg", MODE_CFG, 2'b00, 1'b1, 1'b0, 8'hE4);
        idle("t3_idle", CFG_TMO - 1, 8'hE4);
        step("t3_auto_nml", 1'b0, 1'b0, 8'hE2);

        // BIST completing normally; requests in BIST rejected
        req("bd_bist", MODE_BIST, 2'b00, 1'b1, 1'b0, 8'h88);
        req("bd_req", MODE_NML, 2'b00, 1'b0, 1'b1, 8'h88);
        bist_done = 1'b1;
        step("bd_done", 1'b0, 1'b0, 8'h82);

        // T4: BIST timeout after exactly BIST_TMO cycles
        req("t4_bist", MODE_BIST, 2'b00, 1'b1, 1'b0, 8'h88);
        idle("t4_idle", BIST_TMO - 1, 8'h88);
        chk("t4_tmo_pre", {31'd0, bist_tmo}, 0);
        step("t4_fsiso", 1'b0, 1'b0, 8'h90);
        chk("t4_tmo", {31'd0, bist_tmo}, 1);
        req("t4_fs_req", MODE_CFG, 2'b00, 1'b0, 1'b1, 8'h90);
        fsiso_clr = 1'b1;
        step("t4_clr", 1'b1, 1'b0, 8'h82);
        chk("t4_tmo_sticky", {31'd0, bist_tmo}, 1);

        // T5: fault collides with request; clear blocked while fault held
        fault = 1'b1;
        req("t5_fault_req", MODE_CFG, 2'b00, 1'b0, 1'b1, 8'h90);
        fsiso_clr = 1'b1;
        step("t5_clr_fault", 1'b0, 1'b1, 8'h90);
        fault = 1'b0;
        fsiso_clr = 1'b1;
        step("t5_clr", 1'b1, 1'b0, 8'h82);

        // Fault from CFG clears adc bits
        req("f_cfg", MODE_CFG, 2'b00, 1'b1, 1'b0, 8'h84);
        req("f_wr", MODE_CFG_WR, 2'b01, 1'b1, 1'b0, 8'hA4);
        fault = 1'b1;
        step("f_fault", 1'b0, 1'b0, 8'h90);
        fault = 1'b0;
        fsiso_clr = 1'b1;
        step("f_clr", 1'b1, 1'b0, 8'h82);

        // T6: async reset in CFG with adc set
        req("t6_cfg", MODE_CFG, 2'b00, 1'b1, 1'b0, 8'h84);
        req("t6_wr", MODE_CFG_WR, 2'b11, 1'b1, 1'b0, 8'hE4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rm", {24'd0, reg_mode}, 32'h01);
        chk("t6.ack", {31'd0, mode_ack}, 0);
        chk("t6.err", {31'd0, mode_err}, 0);
        chk("t6.tmo", {31'd0, bist_tmo}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("t6_reload", 1'b0, 1'b0, 8'h82);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
